// File: rtl/spi_pkg.sv
// spi_pkg: shared definitions for the SPI master slice.
//   - state_t     : engine state encoding (WAIT exists only when
//                   SPI_MASTER_BURST_EN is defined)
//   - CPOL / CPHA : SPI mode 3 constants
//   - DEF_CLK_DIV : default SCK half-period in CLK cycles
//   - DEF_DATA_W  : default bits per transfer
package spi_pkg;

    localparam logic CPOL = 1'b1;
    localparam logic CPHA = 1'b1;

    localparam int unsigned DEF_CLK_DIV = 476;
    localparam int unsigned DEF_DATA_W  = 8;

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        SHIFT,
        TRAIL,
        GAP
`ifdef SPI_MASTER_BURST_EN
        , WAIT
`endif
    } state_t;

endpackage

// File: rtl/spi_clk_div.sv
// spi_clk_div: half-period tick generator.
//   clk     in  system clock
//   rst     in  synchronous active-high reset
//   restart in  forces the count back to zero (state entry)
//   tick    out one-cycle pulse every CLK_DIV cycles after restart
module spi_clk_div
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam logic [15:0] TERM = 16'(CLK_DIV - 1);

    logic [15:0] cnt;

    assign tick = (cnt == TERM);

    always_ff @(posedge clk) begin
        if (rst || restart || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

endmodule

// File: rtl/spi_master.sv
// spi_master: SPI mode 3 master, MSB first, single word per transfer.
//   CLK, RST          clock and synchronous active-high reset
//   START, TX_DATA    transfer request and word to send
//   HOLD              keep SSEL low between words (burst builds only)
//   BUSY, DONE        engine busy flag, one-cycle completion pulse
//   RX_DATA           last received word
//   SCK, SSEL, MOSI   SPI outputs (SSEL active-low), MISO SPI input
// Optional feature: define SPI_MASTER_BURST_EN to build the WAIT state
// that chains words without releasing SSEL.
module spi_master
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEF_CLK_DIV,
    parameter int unsigned DATA_W  = DEF_DATA_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic [DATA_W-1:0] TX_DATA,
    input  logic              HOLD,
    output logic              BUSY,
    output logic              DONE,
    output logic [DATA_W-1:0] RX_DATA,
    output logic              SCK,
    output logic              SSEL,
    output logic              MOSI,
    input  logic              MISO
);

    localparam int unsigned   CW       = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);

    state_t            state;
    logic [DATA_W-1:0] tx_sr;
    logic [DATA_W-1:0] rx_sr;
    logic [DATA_W-1:0] rx_next;
    logic [CW-1:0]     bit_cnt;
    logic              tick;
    logic              div_restart;

    assign rx_next = {rx_sr[DATA_W-2:0], MISO};

    // Divider is held at zero in the states left by an input event rather
    // than a tick, so the following state always starts a full half-period.
    always_comb begin
        div_restart = 1'b0;
        if (state == IDLE) div_restart = 1'b1;
`ifdef SPI_MASTER_BURST_EN
        if (state == WAIT) div_restart = 1'b1;
`endif
    end

    spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk     (CLK),
        .rst     (RST),
        .restart (div_restart),
        .tick    (tick)
    );

`ifdef SPI_MASTER_BURST_EN
    // Set when TRAIL is reached from WAIT: that word already reported DONE.
    logic from_wait;
`else
    logic unused_hold;
    assign unused_hold = HOLD;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            SCK     <= CPOL;
            SSEL    <= 1'b1;
            MOSI    <= 1'b0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            RX_DATA <= '0;
            tx_sr   <= '0;
            rx_sr   <= '0;
            bit_cnt <= '0;
`ifdef SPI_MASTER_BURST_EN
            from_wait <= 1'b0;
`endif
        end else begin
            DONE <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (START) begin
                        tx_sr   <= TX_DATA;
                        MOSI    <= TX_DATA[DATA_W-1];
                        SSEL    <= 1'b0;
                        BUSY    <= 1'b1;
                        bit_cnt <= '0;
                        state   <= LEAD;
                    end
                end
                LEAD: begin
                    if (tick) state <= SHIFT;
                end
                SHIFT: begin
                    if (tick) begin
                        if (SCK) begin
                            // Falling edge; the MSB is already on MOSI for the first one.
                            SCK <= 1'b0;
                            if (bit_cnt != '0) begin
                                MOSI  <= tx_sr[DATA_W-2];
                                tx_sr <= tx_sr << 1;
                            end
                        end else begin
                            SCK   <= 1'b1;
                            rx_sr <= rx_next;
                            if (bit_cnt == LAST_BIT) begin
                                bit_cnt <= '0;
`ifdef SPI_MASTER_BURST_EN
                                if (HOLD) begin
                                    RX_DATA <= rx_next;
                                    DONE    <= 1'b1;
                                    state   <= WAIT;
                                end else begin
                                    from_wait <= 1'b0;
                                    state     <= TRAIL;
                                end
`else
                                state <= TRAIL;
`endif
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end
                end
                TRAIL: begin
                    if (tick) begin
                        SSEL  <= 1'b1;
                        state <= GAP;
`ifdef SPI_MASTER_BURST_EN
                        if (!from_wait) begin
                            RX_DATA <= rx_sr;
                            DONE    <= 1'b1;
                        end
`else
                        RX_DATA <= rx_sr;
                        DONE    <= 1'b1;
`endif
                    end
                end
                GAP: begin
                    if (tick) begin
                        BUSY  <= 1'b0;
                        state <= IDLE;
                    end
                end
`ifdef SPI_MASTER_BURST_EN
                WAIT: begin
                    if (START) begin
                        tx_sr   <= TX_DATA;
                        MOSI    <= TX_DATA[DATA_W-1];
                        bit_cnt <= '0;
                        state   <= SHIFT;
                    end else if (!HOLD) begin
                        from_wait <= 1'b1;
                        state     <= TRAIL;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: scoreboard bench for spi_master.
// dutA runs with CLK_DIV=4, dutB with default parameters.
module tb_spi_master;
    import spi_pkg::*;

    typedef struct {
        logic [7:0] rx;
        int         t0;
        int         lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic       startA, holdA, busyA, doneA, sckA, sselA, mosiA, misoA;
    logic [7:0] txA, rxA;
    logic       startB, holdB, busyB, doneB, sckB, sselB, mosiB;
    logic [7:0] txB, rxB;

    logic       loopback;
    logic [7:0] slave_pat;
    int         xfer_rises = 0;

    assign misoA = loopback ? mosiA :
                   ((xfer_rises < 8) ? slave_pat[3'(7 - xfer_rises)] : 1'b0);

    spi_master #(.CLK_DIV(4), .DATA_W(8)) dutA (
        .CLK(clk), .RST(rst), .START(startA), .TX_DATA(txA), .HOLD(holdA),
        .BUSY(busyA), .DONE(doneA), .RX_DATA(rxA),
        .SCK(sckA), .SSEL(sselA), .MOSI(mosiA), .MISO(misoA)
    );

    spi_master dutB (
        .CLK(clk), .RST(rst), .START(startB), .TX_DATA(txB), .HOLD(holdB),
        .BUSY(busyB), .DONE(doneB), .RX_DATA(rxB),
        .SCK(sckB), .SSEL(sselB), .MOSI(mosiB), .MISO(mosiB)
    );

    exp_t qA[$];
    exp_t qB[$];
    int   checks = 0;
    int   errors = 0;

    int fallsA = 0, risesA = 0, sselLowA = 0, mosiLowA = 0;
    int doneCntA = 0, busyCntA = 0, sselRiseA = 0;
    int doneCntB = 0, lastFallB = 0, lastRiseB = 0;
    logic prev_sckA = 1'b1, prev_sselA = 1'b1, prev_sckB = 1'b1;

    int sF, sR, sL, sM, sD, sB, sS;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic snap();
        sF = fallsA; sR = risesA; sL = sselLowA; sM = mosiLowA;
        sD = doneCntA; sB = busyCntA; sS = sselRiseA;
    endtask

    task automatic startA_tx(input logic [7:0] d, input bit push, input int lat);
        exp_t e;
        txA    = d;
        startA = 1'b1;
        if (push) begin
            e.rx = d; e.t0 = cyc; e.lat = lat;
            qA.push_back(e);
        end
        @(negedge clk);
        startA = 1'b0;
    endtask

    task automatic wait_idleA(input string nm, input int budget);
        int n = 0;
        while (busyA && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(nm, int'(busyA), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_doneA(input string nm, input int budget);
        int n = 0;
        while (!doneA && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(nm, int'(doneA), 1);
    endtask

    initial begin
        exp_t e;
        int   n;
        rst = 1'b1;
        startA = 1'b0; holdA = 1'b0; txA = '0;
        startB = 1'b0; holdB = 1'b0; txB = '0;
        loopback = 1'b1; slave_pat = 8'h00;

        fork
            forever begin
                @(negedge clk);
                if (prev_sckA && !sckA) fallsA++;
                if (!prev_sckA && sckA) risesA++;
                if (!prev_sselA && sselA) sselRiseA++;
                if (sselA) xfer_rises = 0;
                else if (!prev_sckA && sckA) xfer_rises++;
                if (!sselA) sselLowA++;
                if (!sselA && !mosiA) mosiLowA++;
                if (busyA) busyCntA++;
                if (doneA) begin
                    doneCntA++;
                    if (qA.size() == 0) chk("unexpected_done_A", 1, 0);
                    else begin
                        e = qA.pop_front();
                        chk("rx_A", int'(rxA), int'(e.rx));
                        chk("done_lat_A", cyc - e.t0, e.lat);
                    end
                end
                prev_sckA  = sckA;
                prev_sselA = sselA;

                if (prev_sckB && !sckB) lastFallB = cyc;
                if (!prev_sckB && sckB) lastRiseB = cyc;
                if (doneB) begin
                    doneCntB++;
                    if (qB.size() == 0) chk("unexpected_done_B", 1, 0);
                    else begin
                        e = qB.pop_front();
                        chk("rx_B", int'(rxB), int'(e.rx));
                        chk("done_lat_B", cyc - e.t0, e.lat);
                    end
                end
                prev_sckB = sckB;
            end
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_sck", int'(sckA), 1);
        chk("rst_ssel", int'(sselA), 1);
        chk("rst_mosi", int'(mosiA), 0);
        chk("rst_busy", int'(busyA), 0);
        chk("rst_done", int'(doneA), 0);
        chk("rst_rx", int'(rxA), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Loopback 0xA5: DONE 73 cycles after START, 8+8 edges, SSEL low 72
        snap();
        startA_tx(8'hA5, 1, 73);
        wait_idleA("timeout_a5", 200);
        chk("a5_falls", fallsA - sF, 8);
        chk("a5_rises", risesA - sR, 8);
        chk("a5_ssel_low", sselLowA - sL, 72);
        chk("a5_dones", doneCntA - sD, 1);
        chk("a5_busy_cycles", busyCntA - sB, 76);

        // Slave pattern 0x3C with TX 0xFF
        loopback = 1'b0; slave_pat = 8'h3C;
        snap();
        startA_tx(8'hFF, 0, 0);
        e.rx = 8'h3C; e.t0 = cyc - 1; e.lat = 73;
        qA.push_back(e);
        wait_idleA("timeout_3c", 200);
        chk("ff_mosi_low", mosiLowA - sM, 0);
        chk("3c_dones", doneCntA - sD, 1);
        loopback = 1'b1;

        // START re-issued mid-transfer must be ignored
        snap();
        startA_tx(8'h3C, 1, 73);
        repeat (9) @(negedge clk);
        txA = 8'hFF; startA = 1'b1;
        @(negedge clk);
        startA = 1'b0;
        wait_idleA("timeout_ign", 200);
        chk("ign_dones", doneCntA - sD, 1);
        chk("ign_falls", fallsA - sF, 8);
        chk("ign_rises", risesA - sR, 8);
        chk("ign_busy_cycles", busyCntA - sB, 76);
        repeat (20) @(negedge clk);
        chk("ign_no_restart", int'(busyA), 0);

        // Reset after the 3rd rising SCK edge aborts without DONE
        snap();
        startA_tx(8'h96, 0, 0);
        n = 0;
        while (xfer_rises < 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("abort_reach_3rd_rise", int'(xfer_rises >= 3), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_sck", int'(sckA), 1);
        chk("abort_ssel", int'(sselA), 1);
        chk("abort_busy", int'(busyA), 0);
        chk("abort_rx", int'(rxA), 0);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        chk("abort_no_done", doneCntA - sD, 0);
        chk("abort_idle", int'(busyA), 0);
        snap();
        startA_tx(8'h5A, 1, 73);
        wait_idleA("timeout_5a", 200);
        chk("5a_dones", doneCntA - sD, 1);
        chk("5a_rises", risesA - sR, 8);

`ifdef SPI_MASTER_BURST_EN
        // Burst: SSEL held low across two words, one DONE per word
        snap();
        holdA = 1'b1;
        startA_tx(8'h12, 1, 69);
        wait_doneA("timeout_burst1", 200);
        startA_tx(8'h34, 1, 65);
        wait_doneA("timeout_burst2", 200);
        @(negedge clk);
        holdA = 1'b0;
        wait_idleA("timeout_burst_end", 200);
        chk("burst_dones", doneCntA - sD, 2);
        chk("burst_ssel_rises", sselRiseA - sS, 1);
        chk("burst_falls", fallsA - sF, 16);
`endif

        // Default divider: half-period 476, DONE at 8569
        txB = 8'h81; startB = 1'b1;
        e.rx = 8'h81; e.t0 = cyc; e.lat = 8569;
        qB.push_back(e);
        @(negedge clk);
        startB = 1'b0;
        n = 0;
        while (busyB && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_B", int'(busyB), 0);
        repeat (3) @(negedge clk);
        chk("B_half_period", lastRiseB - lastFallB, 476);
        chk("B_dones", doneCntB, 1);

        chk("qA_empty", qA.size(), 0);
        chk("qB_empty", qB.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
